fft_load_ctrl: RTL
==================

FFT_LOAD_CTRL -- requirements
Module: fft_load_ctrl

Interface
REQ-001 SHALL have parameter A_BIT, default 8, per-bank address width; frame length N = 4*2^A_BIT samples.
REQ-002 SHALL have parameter S_BIT, default 16, ADC sample width; equals D_BIT-1 of the FFT core.
REQ-003 SHALL have port iCLK, input, 1, sole clock, rising edge.
REQ-004 SHALL have port iRESET, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iSAMPLE, input, S_BIT, ADC sample, two's complement.
REQ-006 SHALL have port iVALID, input, 1, iSAMPLE valid this cycle.
REQ-007 SHALL have port iFLUSH, input, 1, synchronous frame abort.
REQ-008 SHALL have port iFFT_RDY, input, 1, one-cycle pulse from the FFT core at transform end.
REQ-009 SHALL have port oREADY, input-accept flag, output, 1, high only in state LOAD.
REQ-010 SHALL have port oDATA, output, S_BIT, sample to the FFT data input.
REQ-011 SHALL have port oADDR_WR, output, A_BIT, write address shared by all four banks.
REQ-012 SHALL have ports oWE_0..oWE_3, output, 1 each, per-bank write enables.
REQ-013 SHALL have port oSTART, output, 1, one-cycle transform start pulse.
REQ-014 SHALL have port oDROP_CNT, output, 16, dropped-sample count.

Function
REQ-015 SHALL implement states LOAD, START, WAIT; a sample is accepted when iVALID=1 and state=LOAD.
REQ-016 SHALL keep frame counter cnt, width A_BIT+2; accepted sample n goes to bank n[1:0], address n[A_BIT+1:2].
REQ-017 SHALL register write outputs: sample accepted at cycle t gives oDATA=iSAMPLE, oADDR_WR, exactly one oWE_k=1 at t+1; all oWE low otherwise; oDATA/oADDR_WR hold last value.
REQ-018 SHALL increment cnt per accepted sample; on accepting n=N-1, cnt wraps to 0 and state becomes START at t+1.
REQ-019 SHALL assert oSTART for exactly one cycle while in START (t+2 relative to last accept), then enter WAIT.
REQ-020 SHALL leave WAIT for LOAD on the cycle after iFFT_RDY=1; iFFT_RDY in LOAD or START SHALL be ignored.
REQ-021 SHALL treat iVALID=1 outside LOAD as a dropped sample: no write, no counter change.
REQ-022 SHALL on iFLUSH=1 force state LOAD, cnt=0, oWE all 0, oSTART 0 next cycle; iFLUSH overrides a simultaneous iVALID, iFFT_RDY or last-sample accept.

Reset
REQ-023 SHALL on iRESET=0 immediately set state LOAD, cnt=0, oDATA=0, oADDR_WR=0, oWE_0..3=0, oSTART=0, oDROP_CNT=0.
REQ-024 SHALL on reset mid-frame discard partial frame; first post-reset sample goes to bank 0, address 0.

Configuration
REQ-025 SHALL with FFT_LOAD_DROP_CNT_EN defined increment oDROP_CNT per dropped sample (REQ-021), saturate at 16'hFFFF, clear only by reset.
REQ-026 SHALL with FFT_LOAD_DROP_CNT_EN undefined drive oDROP_CNT constant 0 and build no counter logic.

Verification (A_BIT=2, N=16)
REQ-027 SHALL check: 16 back-to-back samples 0..15 -> sample k written to bank k%4, address k/4, one cycle after accept; oSTART single pulse 2 cycles after 16th accept.
REQ-028 SHALL check: iVALID toggling 1/0 for 32 cycles -> same 16 writes in order, oSTART once, no write in gap cycles.
REQ-029 SHALL check: 5 samples in WAIT then iFFT_RDY pulse -> no writes, oREADY 0 until cycle after pulse, oDROP_CNT=5 with macro, 0 without.
REQ-030 SHALL check: iFLUSH after 7 samples, then 16 samples -> next write bank 0 addr 0, oSTART only after full new frame.
REQ-031 SHALL check: iRESET low after 10 samples -> all outputs 0 during reset; post-reset frame loads from bank 0 addr 0.
REQ-032 SHALL check: iFLUSH coincident with 16th accept -> no write, no oSTART, state LOAD, cnt 0.

Source files
------------

// File: rtl/fft_load_ctrl_if.sv
// Sample-loader bus between the ADC-side source and the FFT bank memories.
// The master modport is the sample source; the slave modport is fft_load_ctrl.
interface fft_load_ctrl_if #(
  parameter int A_BIT = 8,
  parameter int S_BIT = 16
);
  logic [S_BIT-1:0] iSAMPLE;
  logic             iVALID;
  logic             iFLUSH;
  logic             iFFT_RDY;
  logic             oREADY;
  logic [S_BIT-1:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic             oWE_0;
  logic             oWE_1;
  logic             oWE_2;
  logic             oWE_3;
  logic             oSTART;
  logic [15:0]      oDROP_CNT;

  modport master (
    output iSAMPLE, iVALID, iFLUSH, iFFT_RDY,
    input  oREADY, oDATA, oADDR_WR, oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oDROP_CNT
  );

  modport slave (
    input  iSAMPLE, iVALID, iFLUSH, iFFT_RDY,
    output oREADY, oDATA, oADDR_WR, oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oDROP_CNT
  );
endinterface

// File: rtl/fft_load_ctrl.sv
// Loads one frame of 4*2^A_BIT samples interleaved over four FFT banks, then starts the transform.
// Define FFT_LOAD_DROP_CNT_EN to count samples that arrive while not loading.
module fft_load_ctrl #(
  parameter int A_BIT = 8,
  parameter int S_BIT = 16
) (
  input  logic            iCLK,
  input  logic            iRESET,
  fft_load_ctrl_if.slave  bus
);

  localparam int C_BIT = A_BIT + 2;
  localparam logic [C_BIT-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [C_BIT-1:0] cnt_reg;
  logic [S_BIT-1:0] data_reg;
  logic [A_BIT-1:0] addr_reg;
  logic [3:0]       we_reg;
  logic             start_reg;

  logic             accept;
  logic [3:0]       we_next;

  // A flush wins over a simultaneous accept, so nothing is written that cycle.
  assign accept = bus.iVALID && (state_reg == LOAD) && !bus.iFLUSH;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_we
      assign we_next[gi] = accept && (cnt_reg[1:0] == 2'(gi));
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      we_reg    <= '0;
      start_reg <= 1'b0;
    end else begin
      we_reg    <= we_next;
      start_reg <= 1'b0;
      if (accept) begin
        data_reg <= bus.iSAMPLE;
        addr_reg <= cnt_reg[C_BIT-1:2];
      end
      if (bus.iFLUSH) begin
        state_reg <= LOAD;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          LOAD: begin
            if (bus.iVALID) begin
              cnt_reg <= cnt_reg + 1'b1;
              if (cnt_reg == CNT_LAST) begin
                state_reg <= START;
              end
            end
          end
          START: begin
            start_reg <= 1'b1;
            state_reg <= WAIT;
          end
          WAIT: begin
            if (bus.iFFT_RDY) begin
              state_reg <= LOAD;
            end
          end
          default: state_reg <= LOAD;
        endcase
      end
    end
  end

  assign bus.oREADY   = (state_reg == LOAD);
  assign bus.oDATA    = data_reg;
  assign bus.oADDR_WR = addr_reg;
  assign bus.oWE_0    = we_reg[0];
  assign bus.oWE_1    = we_reg[1];
  assign bus.oWE_2    = we_reg[2];
  assign bus.oWE_3    = we_reg[3];
  assign bus.oSTART   = start_reg;

`ifdef FFT_LOAD_DROP_CNT_EN
  logic [15:0] drop_reg;

  // Saturating; only reset clears it, a flush does not.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      drop_reg <= '0;
    end else if (bus.iVALID && (state_reg != LOAD) && (drop_reg != 16'hFFFF)) begin
      drop_reg <= drop_reg + 16'd1;
    end
  end

  assign bus.oDROP_CNT = drop_reg;
`else
  assign bus.oDROP_CNT = '0;
`endif

endmodule
